// File: rtl/test003_pkg.sv
// Shared types and elaboration-time constants for the test003 self-test block.
package test003_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WRITE,
    READ_ADDR,
    READ_ACC,
    CHECK
  } state_e;

  // Index width for an n-deep array; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Mask selecting the low w bits of a 64-bit value.
  function automatic logic [63:0] width_mask(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'(1) << w) - 64'(1));
  endfunction

  // Sum of 3*i for i in [0, n), reduced mod 2^w.
  function automatic logic [63:0] exp_sum(input int unsigned n, input int unsigned w);
    logic [63:0] nn;
    nn = 64'(n);
    return ((64'(3) * nn * (nn - 64'(1))) / 64'(2)) & width_mask(w);
  endfunction

  // Value of the last array element, 3*(n-1), reduced mod 2^w.
  function automatic logic [63:0] exp_last(input int unsigned n, input int unsigned w);
    return (64'(3) * (64'(n) - 64'(1))) & width_mask(w);
  endfunction

endpackage

// File: rtl/test003_ram.sv
// N x W simple dual-port RAM: one write port, one read port, 1-cycle registered read, no reset.
module test003_ram
  import test003_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned W  = 32,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/test003.sv
// Hardware self-test leaf: fills a RAM with 3*i, reads it back, sums and checks it.
module test003
  import test003_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic test_req,
  output logic test_busy,
  output logic test_return
);

  localparam int unsigned   IW       = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [W-1:0]  EXP_SUM  = W'(exp_sum(N, W));
  localparam logic [W-1:0]  EXP_LAST = W'(exp_last(N, W));

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  acc_q;
  logic          err_q;
  logic          busy_q;
  logic          ret_q;

  logic          ram_we;
  logic [IW-1:0] ram_waddr;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;

  // Write 3*index formed as shift-and-add; the read address tracks the same index.
  assign ram_we    = (state_q == WRITE);
  assign ram_waddr = idx_q;
  assign ram_wdata = (W'(idx_q) << 1) + W'(idx_q);

  test003_ram #(
    .N  (N),
    .W  (W),
    .IW (IW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (idx_q),
    .rdata_o (ram_rdata)
  );

  // Call sequencer: init, fill, read-accumulate pairs, final check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (test_req) begin
            state_q <= INIT;
            busy_q  <= 1'b1;
          end
        end
        INIT: begin
          idx_q   <= '0;
          acc_q   <= '0;
          err_q   <= 1'b0;
          state_q <= WRITE;
        end
        WRITE: begin
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= READ_ADDR;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        READ_ADDR: begin
          state_q <= READ_ACC;
        end
        READ_ACC: begin
          acc_q <= acc_q + ram_rdata;
          if ((idx_q == LAST_IDX) && (ram_rdata != EXP_LAST)) begin
            err_q <= 1'b1;
          end
          if (idx_q < LAST_IDX) begin
            idx_q   <= idx_q + IW'(1);
            state_q <= READ_ADDR;
          end else begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          ret_q   <= (acc_q == EXP_SUM) && !err_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign test_busy   = busy_q;
  assign test_return = ret_q;

endmodule

// File: tb/tb_test003.sv
// Scoreboard bench for test003: expected call results queued at request, checked at busy fall.
module tb_test003;

  localparam int unsigned N        = 16;
  localparam int unsigned W        = 32;
  localparam int          CALL_LEN = 3 * N + 2;

  typedef struct {
    logic ret;
    bit   chk_gap;
  } exp_t;

  logic clk;
  logic reset;
  logic test_req;
  logic test_busy;
  logic test_return;

  exp_t sb[$];
  exp_t cur;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rises       = 0;
  int dones       = 0;
  int start_cyc   = 0;
  int last_fall   = 0;
  bit in_call     = 0;
  bit prev_busy   = 0;
  bit ret_moved   = 0;
  logic ret_at_start;

  test003 #(.N(N), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .test_req    (test_req),
    .test_busy   (test_busy),
    .test_return (test_return)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_dones(input int target);
    int n = 0;
    while (dones < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("wait_done", 32'(dones), 32'(target));
  endtask

  // Monitor: pops one expectation per call and checks length, result, gap and return stability.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_call   = 0;
        prev_busy = 0;
      end else begin
        if (test_busy && !prev_busy) begin
          rises++;
          if (sb.size() == 0) begin
            check("unexpected_call", 32'(1), 32'(0));
          end else begin
            cur          = sb.pop_front();
            in_call      = 1;
            start_cyc    = cyc;
            ret_at_start = test_return;
            ret_moved    = 0;
            if (cur.chk_gap) check("idle_gap", 32'(cyc - last_fall), 32'(1));
          end
        end else if (test_busy && in_call && (test_return !== ret_at_start)) begin
          ret_moved = 1;
        end
        if (!test_busy && prev_busy && in_call) begin
          in_call   = 0;
          dones++;
          last_fall = cyc;
          check("call_len", 32'(cyc - start_cyc), 32'(CALL_LEN));
          check("result", 32'(test_return), 32'(cur.ret));
          check("ret_hold", 32'(ret_moved), 32'(0));
        end
        prev_busy = test_busy;
      end
    end
  end

  initial begin
    int n;
    reset    = 1'b1;
    test_req = 1'b0;

    // Reset held with req low: outputs stay quiet.
    repeat (3) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(test_busy), 32'(0));
      check("rst_ret", 32'(test_return), 32'(0));
    end
    @(negedge clk);
    reset = 1'b0;

    // Idle with no request.
    while (cyc < 100) begin
      @(negedge clk);
      check("idle_busy", 32'(test_busy), 32'(0));
    end

    // Held request: two back-to-back calls with a one-cycle idle gap.
    test_req = 1'b1;
    sb.push_back('{ret: 1'b1, chk_gap: 1'b0});
    sb.push_back('{ret: 1'b1, chk_gap: 1'b1});
    n = 0;
    while (rises < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("second_start", 32'(rises), 32'(2));
    test_req = 1'b0;
    wait_dones(2);

    // Single pulse, with pulses during busy that must be ignored.
    repeat (3) @(negedge clk);
    test_req = 1'b1;
    sb.push_back('{ret: 1'b1, chk_gap: 1'b0});
    @(negedge clk);
    test_req = 1'b0;
    repeat (10) @(negedge clk);
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    repeat (15) @(negedge clk);
    test_req = 1'b1;
    repeat (2) @(negedge clk);
    test_req = 1'b0;
    wait_dones(3);
    repeat (5) @(negedge clk);
    check("no_extra_busy", 32'(test_busy), 32'(0));
    check("no_extra_rise", 32'(rises), 32'(3));

    // Reset 20 cycles into a call aborts asynchronously.
    test_req = 1'b1;
    sb.push_back('{ret: 1'b1, chk_gap: 1'b0});
    @(negedge clk);
    test_req = 1'b0;
    repeat (19) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_busy", 32'(test_busy), 32'(0));
    check("abort_ret", 32'(test_return), 32'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    test_req = 1'b1;
    sb.push_back('{ret: 1'b1, chk_gap: 1'b0});
    @(negedge clk);
    test_req = 1'b0;
    wait_dones(4);

    // Corrupt element 15 on its write: call must fail.
    repeat (3) @(negedge clk);
    test_req = 1'b1;
    sb.push_back('{ret: 1'b0, chk_gap: 1'b0});
    @(negedge clk);
    test_req = 1'b0;
    n = 0;
    while (!(dut.ram_we && (dut.ram_waddr == 4'd15)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("corrupt_window", 32'(dut.ram_we), 32'(1));
    force dut.ram_wdata = 32'h0;
    @(negedge clk);
    release dut.ram_wdata;
    wait_dones(5);

    // Clean call afterwards recovers.
    repeat (3) @(negedge clk);
    test_req = 1'b1;
    sb.push_back('{ret: 1'b1, chk_gap: 1'b0});
    @(negedge clk);
    test_req = 1'b0;
    wait_dones(6);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'(0));
    check("final_ret", 32'(test_return), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
